// File: rtl/simple_processor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simple_processor_pkg
//  Purpose  : Shared sizing constants and types for the simple processor
//             datapath (register file, scoreboard, ALU).
//  Contents : DATA_WIDTH     - datapath width
//             NUM_REGS       - architectural register count (x0 hardwired 0)
//             REG_ADDR_WIDTH - register address width
//             reg_addr_t     - register address type
//  Revision : 1.0  initial release
// ============================================================================
package simple_processor_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int NUM_REGS       = 32;
   localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage : simple_processor_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : rf_scoreboard
//  Purpose  : Per-register busy bits for the register file plus the issue
//             stall equation (RAW on rs1/rs2, WAW on rd).
//  Ports    : clk_i, arst_i        - clock, async active-high reset
//             rs1/rs2/rd_addr_i    - addresses of the issuing instruction
//             rs2_used_i           - instruction actually reads rs2
//             issue_valid_i        - instruction presented for issue
//             wb_valid_i/wb_addr_i - writeback strobe and destination
//             stall_o              - issue blocked this cycle
//             issue_fire_o         - instruction accepted this cycle
//  Options  : REG_FILE_SB_WB_BYPASS_EN - a writeback matching rs1/rs2 in the
//             current cycle releases that register for the stall equation.
//  Revision : 1.0  initial release
// ============================================================================
module rf_scoreboard #(
   parameter  int NUM_REGS   = 32,
   localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
   input  logic                  rs2_used_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   input  logic                  issue_valid_i,
   input  logic                  wb_valid_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   output logic                  stall_o,
   output logic                  issue_fire_o
);

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_wb_clr;     // one-hot writeback destination
   logic [NUM_REGS-1:0] w_issue_set;  // one-hot destination of a fired issue
   logic [NUM_REGS-1:0] w_eff_busy;   // busy view used by the stall equation
   logic                w_stall;
   logic                w_fire;

   always_comb begin
      w_wb_clr = '0;
      if (wb_valid_i && (wb_addr_i != '0))
         w_wb_clr[wb_addr_i] = 1'b1;
   end

`ifdef REG_FILE_SB_WB_BYPASS_EN
   // A writeback landing on a source register this cycle is forwarded by the
   // read port, so that register no longer blocks issue.
   logic [NUM_REGS-1:0] w_src_mask;

   always_comb begin
      w_src_mask             = '0;
      w_src_mask[rs1_addr_i] = 1'b1;
      w_src_mask[rs2_addr_i] = 1'b1;
      w_eff_busy             = r_busy & ~(w_wb_clr & w_src_mask);
   end
`else
   always_comb begin
      w_eff_busy = r_busy;
   end
`endif

   // busy[0] is never set, so address 0 drops out of every term below.
   assign w_stall = issue_valid_i &&
                    (w_eff_busy[rs1_addr_i] ||
                     (rs2_used_i && w_eff_busy[rs2_addr_i]) ||
                     w_eff_busy[rd_addr_i]);

   // Reset forces fire low so nothing can be accepted while state is cleared.
   assign w_fire = issue_valid_i && !w_stall && !arst_i;

   always_comb begin
      w_issue_set = '0;
      if (w_fire && (rd_addr_i != '0))
         w_issue_set[rd_addr_i] = 1'b1;
   end

   // Set is applied after clear: a younger issue to the same register keeps
   // it busy even when the older result retires on the same edge.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i)
         r_busy <= '0;
      else
         r_busy <= (r_busy & ~w_wb_clr) | w_issue_set;
   end

   assign stall_o      = w_stall;
   assign issue_fire_o = w_fire;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Purpose  : Architectural register file with busy scoreboard. Supplies
//             rs1/rs2 operands to the ALU, takes ALU writeback, and stalls
//             issue on pending RAW/WAW hazards.
//  Ports    : clk_i, arst_i         - clock, async active-high reset
//             rs1/rs2_addr_i        - source addresses (combinational read)
//             rs2_used_i            - 0 for immediate forms (rs2 ignored)
//             rd_addr_i             - destination of the issuing instruction
//             issue_valid_i         - instruction presented for issue
//             rs1/rs2_data_o        - operand data to the ALU
//             stall_o, issue_fire_o - issue handshake results
//             wb_valid_i/addr/data  - result writeback
//  Options  : REG_FILE_SB_WB_BYPASS_EN - forward same-cycle writeback data
//             onto matching read ports.
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_sb
   import simple_processor_pkg::*;
#(
   parameter  int NUM_REGS   = simple_processor_pkg::NUM_REGS,
   localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
   input  logic                  rs2_used_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   input  logic                  issue_valid_i,
   output logic [DATA_WIDTH-1:0] rs1_data_o,
   output logic [DATA_WIDTH-1:0] rs2_data_o,
   output logic                  stall_o,
   output logic                  issue_fire_o,
   input  logic                  wb_valid_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i
);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] w_rs1_data;
   logic [DATA_WIDTH-1:0] w_rs2_data;

   // Storage. Entry 0 is never written and always reads as zero.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
      end else if (wb_valid_i && (wb_addr_i != '0)) begin
         r_regs[wb_addr_i] <= wb_data_i;
      end
   end

   always_comb begin
      w_rs1_data = (rs1_addr_i == '0) ? '0 : r_regs[rs1_addr_i];
      w_rs2_data = (rs2_addr_i == '0) ? '0 : r_regs[rs2_addr_i];
`ifdef REG_FILE_SB_WB_BYPASS_EN
      // Forwarding is suppressed during reset so the ports read zero.
      if (wb_valid_i && !arst_i && (wb_addr_i != '0)) begin
         if (wb_addr_i == rs1_addr_i)
            w_rs1_data = wb_data_i;
         if (wb_addr_i == rs2_addr_i)
            w_rs2_data = wb_data_i;
      end
`endif
   end

   assign rs1_data_o = w_rs1_data;
   assign rs2_data_o = w_rs2_data;

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk_i         (clk_i),
      .arst_i        (arst_i),
      .rs1_addr_i    (rs1_addr_i),
      .rs2_addr_i    (rs2_addr_i),
      .rs2_used_i    (rs2_used_i),
      .rd_addr_i     (rd_addr_i),
      .issue_valid_i (issue_valid_i),
      .wb_valid_i    (wb_valid_i),
      .wb_addr_i     (wb_addr_i),
      .stall_o       (stall_o),
      .issue_fire_o  (issue_fire_o)
   );

endmodule : reg_file_sb
`default_nettype wire
